// File: rtl/jk_pkg.sv
// Shared definitions for the JK pattern driver.
//   state_e   : driver FSM states (idle / load / drive / check)
//   JK_*      : {j,k} excitation codes
//   jk_excite : excitation needed to move a JK flop from cur to want
// Build option: JK_TOGGLE_EN selects toggle coding (11) for rise and fall
// instead of set (10) / reset (01).
package jk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrive,
    StCheck
  } state_e;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  function automatic logic [1:0] jk_excite(input logic cur, input logic want);
    logic [1:0] code;
    if (cur == want) begin
      code = JK_HOLD;
    end else begin
`ifdef JK_TOGGLE_EN
      code = JK_TOGGLE;
`else
      code = want ? JK_SET : JK_RESET;
`endif
    end
    return code;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Step-rate divider: counter runs 0..DIV-1 (DIV = CLK_HZ/TICK_HZ, DIV >= 4) and
// flags a one-cycle tick while it sits at DIV-1.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   clear_i : synchronous clear of the counter to 0
//   tick_o  : high for the cycle in which the counter equals DIV-1
module tick_divider #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned Div  = CLK_HZ / TICK_HZ;
  localparam int unsigned CntW = $clog2(Div);
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/jk_pattern_driver.sv
// Drives a JK flip-flop through a desired Q sequence, one step per slow tick, and
// checks the flop's Q feedback after each step.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_i         : level, accepted only in idle (abort_i has priority)
//   abort_i         : level, returns to idle from any state, no done pulse
//   pattern_i       : desired Q per step, bit 0 = step 0
//   q_fb_i          : flop Q (asynchronous, two-flop synchronised here)
//   j_o, k_o        : registered excitation
//   busy_o          : high in load/drive/check
//   done_o          : one-cycle pulse after the last check
//   err_o, err_idx_o: sticky mismatch flag and index of the first mismatching step
//   step_idx_o      : current step
// Build option: JK_TOGGLE_EN (see jk_pkg) changes rise/fall coding to toggle.
module jk_pattern_driver
  import jk_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned PAT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [PAT_W-1:0]         pattern_i,
  input  logic                     q_fb_i,
  output logic                     j_o,
  output logic                     k_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [$clog2(PAT_W)-1:0] err_idx_o,
  output logic [$clog2(PAT_W)-1:0] step_idx_o
);

  localparam int unsigned IdxW = $clog2(PAT_W);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PAT_W - 1);

  state_e           state_q;
  logic [1:0]       sync_q;
  logic [PAT_W-1:0] pattern_q;
  logic [IdxW-1:0]  step_idx_q;
  logic [IdxW-1:0]  err_idx_q;
  logic             err_q;
  logic             done_q;
  logic [1:0]       jk_q;
  logic             q_sync;
  logic             want;
  logic             tick;

  assign q_sync = sync_q[1];
  assign want   = pattern_q[step_idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], q_fb_i};
    end
  end

  // The counter only runs while driving, so every step holds j/k for exactly
  // DIV cycles regardless of the load/check overhead.
  tick_divider #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_divider (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(state_q != StDrive),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pattern_q  <= '0;
      step_idx_q <= '0;
      err_idx_q  <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      jk_q       <= JK_HOLD;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        // Results of the interrupted run stay visible.
        state_q <= StIdle;
        jk_q    <= JK_HOLD;
      end else begin
        unique case (state_q)
          StIdle: begin
            jk_q <= JK_HOLD;
            if (start_i) begin
              pattern_q  <= pattern_i;
              step_idx_q <= '0;
              err_q      <= 1'b0;
              err_idx_q  <= '0;
              state_q    <= StLoad;
            end
          end
          StLoad: begin
            jk_q    <= jk_excite(q_sync, want);
            state_q <= StDrive;
          end
          StDrive: begin
            if (tick) begin
              jk_q    <= JK_HOLD;
              state_q <= StCheck;
            end
          end
          StCheck: begin
            jk_q <= JK_HOLD;
            if ((q_sync != want) && !err_q) begin
              err_q     <= 1'b1;
              err_idx_q <= step_idx_q;
            end
            if (step_idx_q == LastIdx) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              step_idx_q <= step_idx_q + 1'b1;
              state_q    <= StLoad;
            end
          end
          default: begin
            jk_q    <= JK_HOLD;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign j_o        = jk_q[1];
  assign k_o        = jk_q[0];
  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_idx_o  = err_idx_q;
  assign step_idx_o = step_idx_q;

endmodule

// File: tb/tb_jk_pattern_driver.sv
// Directed bench for jk_pattern_driver (DIV = 10, 8 steps, 12 cycles per step).
// The flop model is an ideal JK flop, clocked shortly after each new excitation
// appears so its Q has passed the synchroniser well before the step's check.
module tb_jk_pattern_driver;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic       abort_i;
  logic [7:0] pattern_i;
  logic       q_fb_i;
  logic       j_o;
  logic       k_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic [2:0] err_idx_o;
  logic [2:0] step_idx_o;

  int n_vec;
  int n_miss;

  jk_pattern_driver #(
    .CLK_HZ (10),
    .TICK_HZ(1),
    .PAT_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .pattern_i (pattern_i),
    .q_fb_i    (q_fb_i),
    .j_o       (j_o),
    .k_o       (k_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .err_idx_o (err_idx_o),
    .step_idx_o(step_idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Excitation expected from the driver for a cur -> want transition.
  function automatic logic [1:0] exp_jk(input logic cur, input logic want);
    if (cur == want) return 2'b00;
`ifdef JK_TOGGLE_EN
    return 2'b11;
`else
    return want ? 2'b10 : 2'b01;
`endif
  endfunction

  function automatic logic jk_flop(input logic q, input logic [1:0] jk);
    case (jk)
      2'b10:   return 1'b1;
      2'b01:   return 1'b0;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  // One run. stick_at >= 0 freezes the model Q from that step on; abort_at /
  // rst_at >= 0 interrupt the run during that step's drive phase.
  task automatic do_run(input string tag, input logic [7:0] pat, input int stick_at,
                        input int abort_at, input int rst_at, input logic exp_err,
                        input int exp_idx);
    logic q_m;
    int   n_done;
    int   done_cyc;
    int   s;
    bit   aborted;
    bit   was_reset;
    q_m       = 1'b0;
    q_fb_i    = 1'b0;
    n_done    = 0;
    done_cyc  = -1;
    aborted   = 1'b0;
    was_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pattern_i = pat;
    start_i   = 1'b1;
    @(posedge clk);  // accepting edge (cycle 0)
    #1;
    start_i = 1'b0;
    for (int n = 1; n <= 110; n++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        n_done++;
        done_cyc = n;
      end
      if (((n - 1) % 12 == 0) && ((n - 1) / 12 < 8) && !aborted) begin
        s = (n - 1) / 12;
        check_eq($sformatf("%s.jk%0d", tag, s), {30'd0, j_o, k_o}, {30'd0, exp_jk(q_m, pat[s])});
        check_eq($sformatf("%s.idx%0d", tag, s), {29'd0, step_idx_o}, s);
        if (!(stick_at >= 0 && s >= stick_at)) q_m = jk_flop(q_m, {j_o, k_o});
        q_fb_i = q_m;
      end
      if (abort_at >= 0 && n == 4 + 12 * abort_at) abort_i = 1'b1;
      if (abort_at >= 0 && n == 5 + 12 * abort_at) begin
        abort_i = 1'b0;
        aborted = 1'b1;
        check_eq({tag, ".abort_jk"}, {30'd0, j_o, k_o}, 32'd0);
        check_eq({tag, ".abort_busy"}, {31'd0, busy_o}, 32'd0);
        check_eq({tag, ".abort_idx"}, {29'd0, step_idx_o}, abort_at);
      end
      if (rst_at >= 0 && n == 4 + 12 * rst_at) begin
        check_eq({tag, ".pre_rst_err"}, {31'd0, err_o}, 32'd1);
        check_eq({tag, ".pre_rst_j"}, {31'd0, j_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq({tag, ".rst_outs"}, {27'd0, j_o, k_o, busy_o, done_o, err_o}, 32'd0);
        check_eq({tag, ".rst_idx"}, {26'd0, err_idx_o, step_idx_o}, 32'd0);
        #1 rst_n = 1'b1;
        was_reset = 1'b1;
        break;
      end
    end
    if (was_reset) begin
      @(posedge clk);
      #1;
      check_eq({tag, ".post_rst_busy"}, {31'd0, busy_o}, 32'd0);
    end else if (aborted) begin
      check_eq({tag, ".abort_no_done"}, n_done, 32'd0);
      check_eq({tag, ".abort_idx_end"}, {29'd0, step_idx_o}, abort_at);
    end else begin
      check_eq({tag, ".done_cnt"}, n_done, 32'd1);
      check_eq({tag, ".done_cyc"}, done_cyc, 32'd96);
      check_eq({tag, ".err"}, {31'd0, err_o}, {31'd0, exp_err});
      check_eq({tag, ".err_idx"}, {29'd0, err_idx_o}, exp_idx);
      check_eq({tag, ".busy_end"}, {31'd0, busy_o}, 32'd0);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    pattern_i = 8'h00;
    q_fb_i    = 1'b0;
    #23;
    check_eq("reset_outs", {27'd0, j_o, k_o, busy_o, done_o, err_o}, 32'd0);
    check_eq("reset_idx", {26'd0, err_idx_o, step_idx_o}, 32'd0);
    rst_n = 1'b1;

    do_run("alt", 8'b1010_1010, -1, -1, -1, 1'b0, 0);
    do_run("stuck", 8'b1010_1010, 3, -1, -1, 1'b1, 3);
    do_run("midrst", 8'b1010_1010, 3, -1, 5, 1'b0, 0);
    do_run("abort", 8'b1010_1010, -1, 4, -1, 1'b0, 0);

    // start and abort together in idle: abort wins.
    q_fb_i    = 1'b0;
    pattern_i = 8'h00;
    start_i   = 1'b1;
    abort_i   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("both_busy%0d", i), {31'd0, busy_o}, 32'd0);
    end
    // start held high: back-to-back runs with one idle cycle between them.
    abort_i = 1'b0;
    @(posedge clk);  // accepting edge
    for (int n = 1; n <= 98; n++) begin
      @(posedge clk);
      #1;
      if (n == 96) begin
        check_eq("b2b_done", {31'd0, done_o}, 32'd1);
        check_eq("b2b_idle", {31'd0, busy_o}, 32'd0);
      end
      if (n == 97) check_eq("b2b_restart", {30'd0, busy_o, done_o}, 32'd2);
      if (n == 98) check_eq("b2b_idx", {29'd0, step_idx_o}, 32'd0);
    end
    start_i = 1'b0;
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    check_eq("b2b_abort", {31'd0, busy_o}, 32'd0);

    // Toggle-coding pattern (also a plain set/reset check in the default build).
    do_run("tog", 8'b1111_0000, -1, -1, -1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
